shift_add_multiplier: RTL and testbench

//   Parametrised sequential shift-add multiplier: datapath (A shift-left, B shift-right,
//   P accumulate, b0/z status) plus an integrated controller FSM.

---
 rtl/shift_add_multiplier.sv | 114 +++++++++++
 tb/tb_shift_add_multiplier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/busy/done handshake and optional signed mode.
// Latency: k+3 edges from the start edge, where k = bit length of |dataB|. Range is 3 to WIDTH+3.
// Backpressure: none. Start is taken only in IDLE. Start while busy is dropped. P is held until the next accepted start.
module shift_add_multiplier #(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic               b0,
    output logic               z,
    output logic [2*WIDTH-1:0] P
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;

    logic             sm;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Operands are stored as magnitudes so the loop is purely unsigned.
    // The most negative value still fits, because its magnitude is 2^(WIDTH-1).
    always_comb begin
        sm    = signed_mode & SIGNED_EN;
        mag_a = (sm && dataA[WIDTH-1]) ? (~dataA + ONE_W) : dataA;
        mag_b = (sm && dataB[WIDTH-1]) ? (~dataB + ONE_W) : dataB;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, mag_a};
                    b_d     = mag_b;
                    p_d     = '0;
                    neg_d   = sm & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Leave as soon as the remaining multiplier bits are all zero.
                if (b_q == '0) begin
                    state_d = ST_SIGN;
                end else begin
                    if (b_q[0]) begin
                        p_d = p_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
            end
            ST_SIGN: begin
                if (neg_q) begin
                    p_d = ~p_q + ONE_P;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign b0   = b_q[0];
    assign z    = (b_q == '0);
    assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier with two builds, SIGNED_EN=1 and SIGNED_EN=0, driven by shared inputs.
// A job-level model predicts busy, done, P, z and b0 every cycle. Directed tests pin literal results.
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;

    logic           busy_o [2];
    logic           done_o [2];
    logic           b0_o   [2];
    logic           z_o    [2];
    logic [2*W-1:0] p_o    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .dataA(dataA), .dataB(dataB), .busy(busy_o[0]), .done(done_o[0]),
        .b0(b0_o[0]), .z(z_o[0]), .P(p_o[0])
    );

    shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .dataA(dataA), .dataB(dataB), .busy(busy_o[1]), .done(done_o[1]),
        .b0(b0_o[1]), .z(z_o[1]), .P(p_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The product is computed as plain integer arithmetic on the operands' numeric values.
    // k is the bit length of |b|.
    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                 output logic [2*W-1:0] res, output int k, output int magb);
        int av, bv, pr;
        av = int'(a);
        bv = int'(b);
        if (sm && a[W-1]) av = av - (1 << W);
        if (sm && b[W-1]) bv = bv - (1 << W);
        pr   = av * bv;
        res  = pr[2*W-1:0];
        magb = (bv < 0) ? -bv : bv;
        k    = 0;
        while ((magb >> k) != 0) k++;
    endfunction

    // Per-build job model: active flag, edges since the start edge, and the job parameters.
    logic           m_act [2] = '{1'b0, 1'b0};
    int             m_n   [2] = '{0, 0};
    int             m_k   [2] = '{0, 0};
    int             m_mb  [2] = '{0, 0};
    logic [2*W-1:0] m_res [2] = '{'0, '0};
    logic [2*W-1:0] m_p   [2] = '{'0, '0};

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 1'b0;
                m_n[i]   = 0;
                m_mb[i]  = 0;
                m_p[i]   = '0;
            end else if (m_act[i]) begin
                m_n[i]++;
                if (m_n[i] == m_k[i] + 2) m_p[i] = m_res[i];
                if (m_n[i] == m_k[i] + 3) m_act[i] = 1'b0;
            end else if (start) begin
                calc(dataA, dataB, signed_mode && (i == 0), m_res[i], m_k[i], m_mb[i]);
                m_act[i] = 1'b1;
                m_n[i]   = 0;
                m_p[i]   = '0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  bcur;
            logic exp_done;
            bcur     = m_act[i] ? (m_mb[i] >> m_n[i]) : 0;
            exp_done = m_act[i] && (m_n[i] == m_k[i] + 2);
            chk($sformatf("busy[%0d]", i), busy_o[i], m_act[i]);
            chk($sformatf("done[%0d]", i), done_o[i], exp_done);
            chk($sformatf("z[%0d]", i), z_o[i], bcur == 0);
            chk($sformatf("b0[%0d]", i), b0_o[i], bcur[0]);
            if (!m_act[i] || m_n[i] >= m_k[i] + 2)
                chk($sformatf("P[%0d]", i), p_o[i], m_p[i]);
        end
    end

    // Returns at the #1 point after some posedge, once both builds are idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o[0] || busy_o[1]) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 30) chk("idle_timeout", busy_o[0] | busy_o[1], 0);
    endtask

    // lat counts edges from the start edge (edge 1) to the edge after which done is seen.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                           output int lat, output logic [2*W-1:0] p);
        wait_idle();
        start       = 1'b1;
        signed_mode = sm;
        dataA       = a;
        dataB       = b;
        @(posedge clk);
        #1;
        start       = 1'b0;
        dataA       = W'($urandom);
        dataB       = W'($urandom);
        signed_mode = 1'($urandom);
        lat = 1;
        while (done_o[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = p_o[0];
    endtask

    initial begin
        int             lat, k, mb;
        logic [2*W-1:0] p, res;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_done", done_o[0], 1'b0);
        chk("rst_P", p_o[0], 8'h00);
        chk("rst_z", z_o[0], 1'b1);
        chk("rst_b0", b0_o[0], 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job(4'd15, 4'd15, 1'b0, lat, p);
        chk("u15x15_P", p, 8'hE1);
        chk("u15x15_lat", lat, 7);

        run_job(4'h8, 4'h7, 1'b1, lat, p);
        chk("s_m8x7_P", p, 8'hC8);
        wait_idle();
        chk("nosign_8x7_P", p_o[1], 8'h38);
        run_job(4'h8, 4'h8, 1'b1, lat, p);
        chk("s_m8xm8_P", p, 8'h40);
        run_job(4'hF, 4'h1, 1'b1, lat, p);
        chk("s_m1x1_P", p, 8'hFF);

        run_job(4'd9, 4'd0, 1'b0, lat, p);
        chk("b0_P", p, 8'h00);
        chk("b0_lat", lat, 3);
        run_job(4'd3, 4'd1, 1'b0, lat, p);
        chk("b1_P", p, 8'h03);
        chk("b1_lat", lat, 4);

        // Hold start with new operands across the whole job. Only the first job may count until IDLE.
        wait_idle();
        start = 1'b1; signed_mode = 1'b0; dataA = 4'd15; dataB = 4'd15;
        @(posedge clk);
        #1;
        dataA = 4'd3; dataB = 4'd2;
        lat = 1;
        while (done_o[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_P", p_o[0], 8'hE1);
        chk("hold_lat", lat, 7);
        @(posedge clk);
        #1;
        chk("hold_idle", busy_o[0], 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("hold_next_P", p_o[0], 8'h06);

        // Reset two edges into a job.
        start = 1'b1; signed_mode = 1'b0; dataA = 4'd15; dataB = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy_o[0], 1'b0);
        chk("mid_rst_done", done_o[0], 1'b0);
        chk("mid_rst_P", p_o[0], 8'h00);
        chk("mid_rst_z", z_o[0], 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_job(4'd6, 4'd5, 1'b0, lat, p);
        chk("post_rst_P", p, 8'h1E);
        chk("post_rst_lat", lat, 6);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    calc(W'(a), W'(b), 1'(s), res, k, mb);
                    run_job(W'(a), W'(b), 1'(s), lat, p);
                    chk($sformatf("sweep_P s%0d a%0d b%0d", s, a, b), p, res);
                    chk($sformatf("sweep_lat s%0d a%0d b%0d", s, a, b), lat, k + 3);
                end
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
